// File: rtl/bitonic_stream_sorter_pkg.sv
// Shared types and stage-schedule helpers for the folded bitonic stream sorter.
// Stage s enumerates (p, q) as p = 1..LP, q = p-1 down to 0.
package bitonic_stream_sorter_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int stage_count(input int lp);
        return (lp * (lp + 1)) / 2;
    endfunction

    function automatic int stage_p(input int s, input int lp);
        int k;
        int res;
        k   = 0;
        res = lp;
        for (int p = 1; p <= lp; p++) begin
            for (int q = p - 1; q >= 0; q--) begin
                res = (k == s) ? p : res;
                k   = k + 1;
            end
        end
        return res;
    endfunction

    function automatic int stage_q(input int s, input int lp);
        int k;
        int res;
        k   = 0;
        res = 0;
        for (int p = 1; p <= lp; p++) begin
            for (int q = p - 1; q >= 0; q--) begin
                res = (k == s) ? q : res;
                k   = k + 1;
            end
        end
        return res;
    endfunction

    // Bit LP of any in-range index is zero, so the final merge runs one way only.
    function automatic logic pair_up(input int i, input int p, input bit dir);
        logic bit_p;
        bit_p = (((i >> p) & 1) != 0) ? 1'b1 : 1'b0;
        return (~bit_p) ^ dir;
    endfunction

endpackage

// File: rtl/bitonic_stream_sorter_cmp_swap.sv
// Combinational two-word compare-exchange; a is the lower-index word.
// up = 1 places the minimum on lo; equal words are never swapped.
module bitonic_stream_sorter_cmp_swap #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          up,
    output logic [DW-1:0] lo,
    output logic [DW-1:0] hi
);

    logic swap_s;

    // Decide the exchange and route the pair.
    always_comb begin
        swap_s = 1'b0;
        if (up) begin
            swap_s = (a > b);
        end else begin
            swap_s = (a < b);
        end
        lo = swap_s ? b : a;
        hi = swap_s ? a : b;
    end

endmodule

// File: rtl/bitonic_stream_sorter.sv
// Folded bitonic sorter: loads 2**LP words serially, runs one compare-exchange
// stage per clock over the buffer, then drains the sorted block serially.
module bitonic_stream_sorter
    import bitonic_stream_sorter_pkg::*;
#(
    parameter int LP  = 3,
    parameter int DW  = 8,
    parameter bit DIR = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    localparam int PN   = 2 ** LP;
    localparam int HALF = PN / 2;
    localparam int S    = stage_count(LP);
    localparam int SW   = (S > 1) ? $clog2(S) : 1;
    localparam logic [LP-1:0] PTR_MAX   = '1;
    localparam logic [SW-1:0] STAGE_MAX = SW'(S - 1);

    state_e        state_r, state_nxt_s;
    logic [LP-1:0] wr_ptr_r, wr_ptr_nxt_s;
    logic [LP-1:0] rd_ptr_r, rd_ptr_nxt_s;
    logic [SW-1:0] stage_r, stage_nxt_s;
    logic [DW-1:0] mem_r       [PN];
    logic [DW-1:0] mem_nxt_s   [PN];
    logic [DW-1:0] stage_out_s [PN];

    int            stage_p_s;
    int            stage_q_s;
    logic [LP-1:0] lo_idx_s [HALF];
    logic [LP-1:0] hi_idx_s [HALF];
    logic [DW-1:0] a_s      [HALF];
    logic [DW-1:0] b_s      [HALF];
    logic [DW-1:0] lo_s     [HALF];
    logic [DW-1:0] hi_s     [HALF];
    logic          up_s     [HALF];

    logic          in_ready_r;
    logic          out_valid_r;
    logic [DW-1:0] out_data_r;
    logic          out_last_r;
    logic          busy_r;

    // Pair k of the current stage: insert a zero at bit q of k for the lower index.
    always_comb begin
        stage_p_s = stage_p(int'(stage_r), LP);
        stage_q_s = stage_q(int'(stage_r), LP);
        for (int k = 0; k < HALF; k++) begin
            lo_idx_s[k] = LP'(((k >> stage_q_s) << (stage_q_s + 1)) | (k & ((1 << stage_q_s) - 1)));
            hi_idx_s[k] = lo_idx_s[k] | LP'(1 << stage_q_s);
            a_s[k]      = mem_r[lo_idx_s[k]];
            b_s[k]      = mem_r[hi_idx_s[k]];
            up_s[k]     = pair_up(int'(lo_idx_s[k]), stage_p_s, DIR);
        end
    end

    for (genvar g = 0; g < HALF; g++) begin : g_cs
        bitonic_stream_sorter_cmp_swap #(
            .DW(DW)
        ) u_cs (
            .a  (a_s[g]),
            .b  (b_s[g]),
            .up (up_s[g]),
            .lo (lo_s[g]),
            .hi (hi_s[g])
        );
    end

    // Scatter the exchanged pairs back to their buffer positions.
    always_comb begin
        for (int j = 0; j < PN; j++) begin
            stage_out_s[j] = mem_r[j];
        end
        for (int k = 0; k < HALF; k++) begin
            stage_out_s[lo_idx_s[k]] = lo_s[k];
            stage_out_s[hi_idx_s[k]] = hi_s[k];
        end
    end

    // Next-state, pointer and buffer update logic.
    always_comb begin
        state_nxt_s  = state_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        stage_nxt_s  = stage_r;
        mem_nxt_s    = mem_r;
        case (state_r)
            LOAD: begin
                if (in_valid && in_ready_r) begin
                    mem_nxt_s[wr_ptr_r] = in_data;
                    wr_ptr_nxt_s        = wr_ptr_r + LP'(1);
                    if (wr_ptr_r == PTR_MAX) begin
                        state_nxt_s = SORT;
                        stage_nxt_s = '0;
                    end else begin
                        state_nxt_s = LOAD;
                    end
                end else begin
                    wr_ptr_nxt_s = wr_ptr_r;
                end
            end
            SORT: begin
                mem_nxt_s = stage_out_s;
                if (stage_r == STAGE_MAX) begin
                    state_nxt_s  = DRAIN;
                    stage_nxt_s  = '0;
                    rd_ptr_nxt_s = '0;
                end else begin
                    stage_nxt_s = stage_r + SW'(1);
                end
            end
            DRAIN: begin
                if (out_ready && out_valid_r) begin
                    rd_ptr_nxt_s = rd_ptr_r + LP'(1);
                    if (rd_ptr_r == PTR_MAX) begin
                        state_nxt_s = LOAD;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end else begin
                    rd_ptr_nxt_s = rd_ptr_r;
                end
            end
            default: begin
                state_nxt_s  = LOAD;
                wr_ptr_nxt_s = '0;
                rd_ptr_nxt_s = '0;
                stage_nxt_s  = '0;
            end
        endcase
    end

    // Control state and block buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= LOAD;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            stage_r  <= '0;
            for (int j = 0; j < PN; j++) begin
                mem_r[j] <= '0;
            end
        end else begin
            state_r  <= state_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            stage_r  <= stage_nxt_s;
            for (int j = 0; j < PN; j++) begin
                mem_r[j] <= mem_nxt_s[j];
            end
        end
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s == LOAD);
            out_valid_r <= (state_nxt_s == DRAIN);
            out_data_r  <= (state_nxt_s == DRAIN) ? mem_nxt_s[rd_ptr_nxt_s] : '0;
            out_last_r  <= (state_nxt_s == DRAIN) && (rd_ptr_nxt_s == PTR_MAX);
            busy_r      <= (state_nxt_s != LOAD);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_bitonic_stream_sorter.sv
// Directed bench for bitonic_stream_sorter: ascending, descending and LP=1 instances
// share one stimulus bus, selected by sel.
module tb_bitonic_stream_sorter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    int         sel;

    logic       a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [7:0] a_out_data;
    logic       d_in_ready, d_out_valid, d_out_last, d_busy;
    logic [7:0] d_out_data;
    logic       s_in_ready, s_out_valid, s_out_last, s_busy;
    logic [3:0] s_out_data;

    logic       obs_in_ready, obs_out_valid, obs_out_last, obs_busy;
    logic [7:0] obs_out_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int din  [8];
    int dexp [8];
    int pat  [6] = '{1, 0, 0, 1, 0, 1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bitonic_stream_sorter #(.LP(3), .DW(8), .DIR(1'b0)) u_asc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && (sel == 0)), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready && (sel == 0)),
        .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy)
    );

    bitonic_stream_sorter #(.LP(3), .DW(8), .DIR(1'b1)) u_desc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && (sel == 1)), .in_ready(d_in_ready), .in_data(in_data),
        .out_valid(d_out_valid), .out_ready(out_ready && (sel == 1)),
        .out_data(d_out_data), .out_last(d_out_last), .busy(d_busy)
    );

    bitonic_stream_sorter #(.LP(1), .DW(4), .DIR(1'b0)) u_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && (sel == 2)), .in_ready(s_in_ready), .in_data(in_data[3:0]),
        .out_valid(s_out_valid), .out_ready(out_ready && (sel == 2)),
        .out_data(s_out_data), .out_last(s_out_last), .busy(s_busy)
    );

    always_comb begin
        obs_in_ready  = a_in_ready;
        obs_out_valid = a_out_valid;
        obs_out_last  = a_out_last;
        obs_busy      = a_busy;
        obs_out_data  = a_out_data;
        if (sel == 1) begin
            obs_in_ready  = d_in_ready;
            obs_out_valid = d_out_valid;
            obs_out_last  = d_out_last;
            obs_busy      = d_busy;
            obs_out_data  = d_out_data;
        end else if (sel == 2) begin
            obs_in_ready  = s_in_ready;
            obs_out_valid = s_out_valid;
            obs_out_last  = s_out_last;
            obs_busy      = s_busy;
            obs_out_data  = {4'b0000, s_out_data};
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input int n, input bit toggle);
        int idx = 0;
        int g = 0;
        bit hs;
        while (idx < n && g < 100) begin
            in_valid = toggle ? ((g % 2) == 0) : 1'b1;
            in_data  = 8'(din[idx]);
            hs = in_valid && obs_in_ready;
            tick();
            g++;
            if (hs) begin
                idx++;
                last_acc = cyc;
            end
        end
        in_valid = 1'b0;
        check("send_count", idx, n);
    endtask

    task automatic recv_block(input int n, input int take, input int s_exp, input bit bp, input bit noise);
        int g = 0;
        int k = 0;
        int c = 0;
        bit hs;
        if (noise) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
        end
        while (!obs_out_valid && g < 50) begin
            check("sort_in_ready", int'(obs_in_ready), 0);
            check("sort_busy", int'(obs_busy), 1);
            tick();
            g++;
        end
        in_valid = 1'b0;
        check("latency", cyc - last_acc, s_exp);
        while (k < take && c < 100) begin
            out_ready = bp ? (pat[c % 6] != 0) : 1'b1;
            check("out_valid", int'(obs_out_valid), 1);
            check("in_ready_drain", int'(obs_in_ready), 0);
            check($sformatf("out_data[%0d]", k), int'(obs_out_data), dexp[k]);
            check($sformatf("out_last[%0d]", k), int'(obs_out_last), (k == n - 1) ? 1 : 0);
            hs = out_ready && obs_out_valid;
            tick();
            c++;
            if (hs) k++;
        end
        out_ready = 1'b0;
        check("recv_count", k, take);
        if (take == n) begin
            check("in_ready_back", int'(obs_in_ready), 1);
            check("out_valid_done", int'(obs_out_valid), 0);
            check("busy_done", int'(obs_busy), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        sel       = 0;
        tick();
        tick();
        check("rst_in_ready", int'(obs_in_ready), 1);
        check("rst_out_valid", int'(obs_out_valid), 0);
        check("rst_out_last", int'(obs_out_last), 0);
        check("rst_out_data", int'(obs_out_data), 0);
        check("rst_busy", int'(obs_busy), 0);
        rst_n = 1'b1;
        tick();

        // Ascending, streaming input and output.
        din  = '{5, 3, 7, 1, 8, 2, 6, 4};
        dexp = '{1, 2, 3, 4, 5, 6, 7, 8};
        send_block(8, 1'b0);
        recv_block(8, 8, 6, 1'b0, 1'b0);

        // Descending instance, then duplicates and extremes.
        sel  = 1;
        dexp = '{8, 7, 6, 5, 4, 3, 2, 1};
        send_block(8, 1'b0);
        recv_block(8, 8, 6, 1'b0, 1'b0);
        din  = '{0, 0, 255, 255, 1, 1, 254, 254};
        dexp = '{255, 255, 254, 254, 1, 1, 0, 0};
        send_block(8, 1'b0);
        recv_block(8, 8, 6, 1'b0, 1'b0);

        // Gapped input plus in_valid noise during SORT.
        sel  = 0;
        din  = '{9, 200, 0, 17, 9, 3, 255, 42};
        dexp = '{0, 3, 9, 9, 17, 42, 200, 255};
        send_block(8, 1'b1);
        recv_block(8, 8, 6, 1'b0, 1'b1);

        // Output backpressure.
        din  = '{4, 4, 2, 9, 0, 7, 1, 3};
        dexp = '{0, 1, 2, 3, 4, 4, 7, 9};
        send_block(8, 1'b0);
        recv_block(8, 8, 6, 1'b1, 1'b0);

        // Reset in the middle of DRAIN.
        din  = '{50, 40, 30, 20, 10, 60, 70, 80};
        dexp = '{10, 20, 30, 40, 50, 60, 70, 80};
        send_block(8, 1'b0);
        recv_block(8, 3, 6, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", int'(obs_out_valid), 0);
        check("midrst_in_ready", int'(obs_in_ready), 1);
        check("midrst_busy", int'(obs_busy), 0);
        check("midrst_out_data", int'(obs_out_data), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        din  = '{7, 6, 5, 4, 3, 2, 1, 0};
        dexp = '{0, 1, 2, 3, 4, 5, 6, 7};
        send_block(8, 1'b0);
        recv_block(8, 8, 6, 1'b0, 1'b0);

        // Two-word instance: single-stage sort.
        sel     = 2;
        din[0]  = 15;
        din[1]  = 0;
        dexp[0] = 0;
        dexp[1] = 15;
        send_block(2, 1'b0);
        recv_block(2, 2, 1, 1'b0, 1'b0);
        din[0]  = 3;
        din[1]  = 3;
        dexp[0] = 3;
        dexp[1] = 3;
        send_block(2, 1'b0);
        recv_block(2, 2, 1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bitonic_stream_sorter.md
Name: bitonic_stream_sorter

Overview:
Sequential, folded counterpart of the combinational bitonic sort network, on the stream side of that interface.
- Accepts one block of 2**LP words serially over a valid/ready input.
- Sorts the block in place by applying one bitonic compare-exchange stage per clock.
- Emits the sorted block serially over a valid/ready output.
- Sits between a narrow producer and consumer where the full parallel network is too large.

Parameters:
LP, 3, log2 of block size; PN = 2**LP words per block; LP >= 1
DW, 8, word width, unsigned
DIR, 0, 0 = ascending output (smallest first), 1 = descending

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer offers in_data
in_ready  output  1  block accepts a word this cycle
in_data  input  DW  input word
out_valid  output  1  out_data is a valid sorted word
out_ready  input  1  consumer accepts out_data
out_data  output  DW  sorted output word
out_last  output  1  high with the final (PN-th) output word
busy  output  1  high in SORT or DRAIN

Behaviour:
- Storage: buf[0..PN-1] of DW bits; wr_ptr and rd_ptr are LP bits each; stage counter sized for S = LP*(LP+1)/2.
- Reset (async assert, rst_n low):
  - state = LOAD; all pointers and counters = 0; buf cleared to 0.
  - in_ready = 1; out_valid = 0; out_last = 0; out_data = 0; busy = 0.
- FSM states: LOAD, SORT, DRAIN.
- LOAD:
  - in_ready = 1.
  - On in_valid & in_ready: buf[wr_ptr] <= in_data; wr_ptr increments.
  - On the accept with wr_ptr == PN-1: wr_ptr wraps to 0; go to SORT next cycle with stage = 0.
  - No partial blocks; a block is always exactly PN words.
- SORT:
  - in_ready = 0; out_valid = 0.
  - Stages are enumerated for p = 1..LP, and for each p, q = p-1 down to 0. Stage index s runs 0..S-1 in that order.
  - Each cycle applies stage s to all PN/2 pairs (i, i^2**q) with bit q of i equal to 0.
  - Pair direction: up = (bit p of i == 0) XOR DIR, with bit LP of i taken as 0.
  - up = 1: lower index receives the min, higher index the max. up = 0: the reverse.
  - Compare is unsigned; equal values are left unswapped.
  - After stage S-1 completes: go to DRAIN, rd_ptr = 0.
  - SORT always takes exactly S cycles (S = 6 for LP = 3, S = 1 for LP = 1).
- DRAIN:
  - out_valid = 1; out_data = buf[rd_ptr]; out_last = (rd_ptr == PN-1).
  - On out_valid & out_ready: rd_ptr increments.
  - On the accept with out_last high: go to LOAD next cycle; rd_ptr wraps to 0.
  - out_data and out_last stay stable while out_ready is low.
- Timing:
  - Last input accepted in cycle T gives SORT in cycles T+1..T+S and first out_valid in cycle T+S+1.
  - Next block's first in_ready comes the cycle after the last output handshake.
  - No overlap between blocks: in_ready and out_valid are never high together.
- busy = (state != LOAD).
- Boundaries:
  - in_valid low in LOAD: no write.
  - in_valid high outside LOAD: ignored, no side effects.
  - out_ready held low: DRAIN stalls indefinitely with no data change.
  - Reset during any state aborts the block immediately and returns to the reset values; the data in flight is discarded.
  - Duplicate values and the extremes 0 and 2**DW-1 must sort correctly.

Decomposition:
- Shared package:
  - function giving stage count S(LP)
  - functions mapping stage index s to (p, q)
  - pair-direction function for (i, p, DIR)
  - state enum {LOAD, SORT, DRAIN}
- Sub-module cmp_swap: combinational two-word compare-exchange with DW and a runtime up input.
  - PN/2 instances are generated per stage slot.
  - Operands are selected by the current stage's q via muxes on buf.

Test Plan:
- LP=3, DW=8, DIR=0; input 5,3,7,1,8,2,6,4 with in_valid held high and out_ready held high -> outputs 1,2,3,4,5,6,7,8; out_last only on 8; first out_valid exactly 7 cycles after the last input accept.
- Same input with DIR=1 -> outputs 8,7,6,5,4,3,2,1; then a second block 0,0,255,255,1,1,254,254 -> outputs 255,255,254,254,1,1,0,0.
- Input 9 with in_valid toggled every other cycle, plus in_valid asserted during SORT -> identical sorted output; no extra words captured.
- Output backpressure: out_ready pattern 1,0,0,1,0,1,... -> each word held stable until accepted; exactly 8 words; in_ready returns 1 cycle after the out_last handshake.
- rst_n pulsed low mid-DRAIN after 3 words -> out_valid = 0 and in_ready = 1 during reset; a following block 7,6,5,4,3,2,1,0 -> outputs 0..7.
- LP=1, DW=4; inputs 15,0 -> outputs 0,15 with SORT lasting 1 cycle; inputs 3,3 -> outputs 3,3.
